// File: rtl/rgmii_udp_rx_parser.sv
// rgmii_udp_rx_parser: captures the UDP/IPv4/Ethernet header, filters the frame and forwards the UDP payload
package rgmii_udp_rx_pkg;
    typedef struct packed { logic [5:0][7:0] fpga; } mac_config_t;
    typedef struct packed { logic [31:0] fpga; } ip_config_t;
    typedef struct packed { logic [15:0] fpga; } port_config_t;
    typedef struct packed { logic reset; logic check_destination; } control_config_t;
    typedef struct packed {
        mac_config_t     mac;
        ip_config_t      ip;
        port_config_t    port;
        control_config_t control;
    } rgmii_config_t;
    typedef struct packed {
        logic [15:0] udp_checksum;
        logic [15:0] udp_length;
        logic [15:0] port_destination;
        logic [15:0] port_source;
        logic [31:0] ip_destination;
        logic [31:0] ip_source;
        logic [15:0] ip_checksum;
        logic [7:0]  protocol;
        logic [7:0]  ttl;
        logic [15:0] flags_fragment;
        logic [15:0] identification;
        logic [15:0] total_length;
        logic [7:0]  tos;
        logic [7:0]  version_ihl;
        logic [15:0] eth_type;
        logic [47:0] mac_source;
        logic [47:0] mac_destination;
    } ethernet_header_t;
endpackage

module rgmii_udp_rx_parser
    import rgmii_udp_rx_pkg::*;
#(
    parameter bit ACCEPT_BROADCAST = 1'b1
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  rgmii_config_t    cfg_i,
    input  logic [7:0]       s_axis_tdata_i,
    input  logic             s_axis_tvalid_i,
    input  logic             s_axis_tlast_i,
    input  logic             s_axis_tuser_i,
    output logic             s_axis_tready_o,
    output logic [7:0]       m_axis_tdata_o,
    output logic             m_axis_tvalid_o,
    output logic             m_axis_tlast_o,
    output logic             m_axis_tuser_o,
    input  logic             m_axis_tready_i,
    output ethernet_header_t header_o,
    output logic             hdr_valid_o,
    output logic             frame_drop_o,
    output logic             frame_err_o
);
    localparam logic [5:0] LAST_BYTE = 6'd41;

    typedef enum logic [1:0] {HEADER, PAYLOAD, DROP} state_t;

    state_t           state, state_nx;
    logic [5:0]       byte_cnt;
    logic [15:0]      remain;
    logic [41:0][7:0] hdr;
    logic [15:0]      udp_len;
    logic             take, mac_match, mac_bcast, ip_match, port_match, dest_ok, hdr_pass;

    assign header_o        = ethernet_header_t'(hdr);
    assign s_axis_tready_o = state != PAYLOAD || !m_axis_tvalid_o || m_axis_tready_i;
    assign take            = s_axis_tvalid_i && s_axis_tready_o;
    assign udp_len         = {hdr[38], hdr[39]};
    assign mac_match       = {hdr[0], hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]} == cfg_i.mac.fpga;
    assign mac_bcast       = ACCEPT_BROADCAST && &hdr[5:0];
    assign ip_match        = {hdr[30], hdr[31], hdr[32], hdr[33]} == cfg_i.ip.fpga;
    assign port_match      = {hdr[36], hdr[37]} == cfg_i.port.fpga;
    assign dest_ok         = !cfg_i.control.check_destination || ((mac_match || mac_bcast) && ip_match && port_match);
    assign hdr_pass        = hdr[12] == 8'h08 && hdr[13] == 8'h00 && hdr[14] == 8'h45 &&
                             hdr[23] == 8'h11 && udp_len >= 16'd8 && dest_ok;

    // State register; control.reset abandons the frame in progress
    always_ff @(posedge clk_i or negedge arstn_i)
        if (!arstn_i) state <= HEADER;
        else state <= cfg_i.control.reset ? HEADER : state_nx;

    // Next state: header decision on its last byte, payload ends on exhausted length or input tlast
    always_comb begin
        state_nx = state;
        if (take)
            case (state)
                HEADER:  state_nx = byte_cnt != LAST_BYTE || s_axis_tlast_i ? HEADER :
                                    (hdr_pass && udp_len != 16'd8) ? PAYLOAD : DROP;
                PAYLOAD: state_nx = s_axis_tlast_i ? HEADER : remain == 16'd1 ? DROP : PAYLOAD;
                default: state_nx = s_axis_tlast_i ? HEADER : DROP;
            endcase
    end

    // Header capture, payload output register, event pulses
    always_ff @(posedge clk_i or negedge arstn_i)
        if (!arstn_i || cfg_i.control.reset) begin
            byte_cnt        <= '0;
            remain          <= '0;
            hdr             <= '0;
            m_axis_tdata_o  <= '0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            m_axis_tuser_o  <= 1'b0;
            hdr_valid_o     <= 1'b0;
            frame_drop_o    <= 1'b0;
            frame_err_o     <= 1'b0;
        end else begin
            hdr_valid_o  <= 1'b0;
            frame_drop_o <= 1'b0;
            frame_err_o  <= take && s_axis_tlast_i && s_axis_tuser_i;
            if (m_axis_tready_i) m_axis_tvalid_o <= 1'b0;
            if (take)
                case (state)
                    HEADER: begin
                        hdr[byte_cnt] <= s_axis_tdata_i;
                        byte_cnt      <= byte_cnt == LAST_BYTE || s_axis_tlast_i ? 6'd0 : byte_cnt + 6'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            hdr_valid_o  <= hdr_pass;
                            frame_drop_o <= !hdr_pass;
                            remain       <= udp_len - 16'd8;
                        end else if (s_axis_tlast_i) frame_drop_o <= 1'b1;
                    end
                    PAYLOAD: begin
                        m_axis_tdata_o  <= s_axis_tdata_i;
                        m_axis_tvalid_o <= 1'b1;
                        m_axis_tlast_o  <= s_axis_tlast_i || remain == 16'd1;
                        m_axis_tuser_o  <= s_axis_tlast_i && remain != 16'd1;
                        remain          <= remain - 16'd1;
                    end
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_rgmii_udp_rx_parser.sv
// tb_rgmii_udp_rx_parser: directed frames checked against a whole-frame behavioural model
module tb_rgmii_udp_rx_parser;
    import rgmii_udp_rx_pkg::*;

    localparam logic [47:0] MAC  = 48'h021122334455;
    localparam logic [31:0] IP   = 32'hC0A80102;
    localparam logic [15:0] PORT = 16'h1234;

    logic clk = 1'b0, arstn = 1'b0;
    rgmii_config_t cfg;
    logic [7:0] s_tdata, m_tdata;
    logic s_tvalid, s_tlast, s_tuser, s_tready;
    logic m_tvalid, m_tlast, m_tuser, m_tready;
    ethernet_header_t hdr;
    logic hdr_valid, frame_drop, frame_err;

    int n_cmp = 0, n_fail = 0;
    int exp_drops = 0, exp_errs = 0, exp_hdrs = 0;
    int drops_seen = 0, errs_seen = 0, hdr_seen = 0, beats_seen = 0;
    logic [7:0]   frame[$];
    logic [9:0]   exp_q[$];
    logic [335:0] exp_hdr_q[$];
    logic [9:0]   last_beat = '0;
    logic [9:0]   e;
    logic [335:0] eh;
    bit rnd_ready = 1'b0;
    int b0, d0;

    rgmii_udp_rx_parser #(.ACCEPT_BROADCAST(1'b1)) dut (
        .clk_i(clk), .arstn_i(arstn), .cfg_i(cfg),
        .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tlast_i(s_tlast),
        .s_axis_tuser_i(s_tuser), .s_axis_tready_o(s_tready),
        .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast),
        .m_axis_tuser_o(m_tuser), .m_axis_tready_i(m_tready),
        .header_o(hdr), .hdr_valid_o(hdr_valid), .frame_drop_o(frame_drop), .frame_err_o(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [335:0] act, input logic [335:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mk_frame(input logic [47:0] dmac, input logic [15:0] etype, input logic [31:0] dip,
                            input logic [15:0] dport, input logic [15:0] ulen, input int npay,
                            input int npad, input logic [7:0] base);
        logic [15:0] tl;
        tl = ulen + 16'd20;
        frame.delete();
        for (int i = 5; i >= 0; i--) frame.push_back(dmac[8*i +: 8]);
        for (int i = 0; i < 6; i++) frame.push_back(i == 0 ? 8'h02 : i == 5 ? 8'h01 : 8'h00);
        frame.push_back(etype[15:8]); frame.push_back(etype[7:0]);
        frame.push_back(8'h45); frame.push_back(8'h00);
        frame.push_back(tl[15:8]); frame.push_back(tl[7:0]);
        frame.push_back(8'hBE); frame.push_back(8'hEF);
        frame.push_back(8'h40); frame.push_back(8'h00);
        frame.push_back(8'h40); frame.push_back(8'h11);
        frame.push_back(8'hAB); frame.push_back(8'hCD);
        frame.push_back(8'hC0); frame.push_back(8'hA8); frame.push_back(8'h01); frame.push_back(8'h01);
        for (int i = 3; i >= 0; i--) frame.push_back(dip[8*i +: 8]);
        frame.push_back(8'h50); frame.push_back(8'h00);
        frame.push_back(dport[15:8]); frame.push_back(dport[7:0]);
        frame.push_back(ulen[15:8]); frame.push_back(ulen[7:0]);
        frame.push_back(8'h00); frame.push_back(8'h00);
        for (int i = 0; i < npay; i++) frame.push_back(8'(base + 8'(i)));
        for (int i = 0; i < npad; i++) frame.push_back(8'h00);
    endtask

    // Whole-frame outcome: short/filtered -> one drop; accepted -> header plus min(udp_len-8, bytes left) beats
    task automatic model_frame(input bit user);
        int L, want, have, n;
        logic [47:0] dmac;
        logic [31:0] dip;
        logic [15:0] dport, ulen;
        logic [335:0] h;
        bit pass;
        L = frame.size();
        if (user) exp_errs++;
        if (L < 42) begin
            exp_drops++;
            return;
        end
        dmac  = {frame[0], frame[1], frame[2], frame[3], frame[4], frame[5]};
        dip   = {frame[30], frame[31], frame[32], frame[33]};
        dport = {frame[36], frame[37]};
        ulen  = {frame[38], frame[39]};
        pass  = frame[12] == 8'h08 && frame[13] == 8'h00 && frame[14] == 8'h45 && frame[23] == 8'h11 &&
                ulen >= 16'd8 && (!cfg.control.check_destination ||
                ((dmac == cfg.mac.fpga || dmac == 48'hFFFFFFFFFFFF) && dip == cfg.ip.fpga && dport == cfg.port.fpga));
        if (!pass) begin
            exp_drops++;
            return;
        end
        for (int k = 0; k < 42; k++) h[8*k +: 8] = frame[k];
        exp_hdrs++;
        exp_hdr_q.push_back(h);
        want = int'(ulen) - 8;
        have = L - 42;
        n = want < have ? want : have;
        for (int i = 0; i < n; i++)
            exp_q.push_back({frame[42+i], i == n - 1, i == n - 1 && have < want});
    endtask

    task automatic send_frame(input int n, input bit user);
        bit acc;
        int w;
        for (int i = 0; i < n; i++) begin
            s_tdata  = frame[i];
            s_tvalid = 1'b1;
            s_tlast  = i == frame.size() - 1;
            s_tuser  = s_tlast && user;
            w = 0;
            do begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk);
                #1;
                w++;
            end while (!acc && w < 1000);
            if (!acc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL s_tready timeout: got 0 expected 1");
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
    endtask

    task automatic settle();
        int w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(posedge clk);
            w++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        chk("hdr_cnt", hdr_seen, exp_hdrs);
        chk("drop_cnt", drops_seen, exp_drops);
        chk("err_cnt", errs_seen, exp_errs);
    endtask

    // Compare process: every consumed beat, every header pulse, pulse counters
    always @(negedge clk) if (arstn) begin
        if (m_tvalid && m_tready) begin
            beats_seen++;
            last_beat = {m_tdata, m_tlast, m_tuser};
            if (exp_q.size() == 0) chk("unexpected_beat", {m_tdata, m_tlast, m_tuser}, 10'h3FF ^ {m_tdata, m_tlast, m_tuser});
            else begin
                e = exp_q.pop_front();
                chk("beat", {m_tdata, m_tlast, m_tuser}, e);
            end
        end
        if (hdr_valid) begin
            hdr_seen++;
            if (exp_hdr_q.size() != 0) begin
                eh = exp_hdr_q.pop_front();
                chk("header", hdr, eh);
            end
        end
        if (frame_drop) drops_seen++;
        if (frame_err) errs_seen++;
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        cfg = '0;
        cfg.mac.fpga = MAC;
        cfg.ip.fpga = IP;
        cfg.port.fpga = PORT;
        cfg.control.check_destination = 1'b1;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_header", hdr, 0);
        chk("rst_pulses", {hdr_valid, frame_drop, frame_err}, 0);
        chk("rst_tready", s_tready, 1);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        // good frame, 4 payload bytes
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd12, 4, 0, 8'hA0);
        model_frame(1'b0);
        b0 = beats_seen;
        send_frame(frame.size(), 1'b0);
        settle();
        chk("t1_beats", beats_seen - b0, 4);
        chk("t1_last", last_beat, {8'hA3, 2'b10});
        chk("t1_ethtype", hdr.eth_type, 16'h0008);
        chk("t1_udplen", hdr.udp_length, 16'h0C00);
        chk("t1_dport", hdr.port_destination, 16'h3412);
        chk("t1_dmac", hdr.mac_destination, 48'h554433221102);
        chk("t1_proto", hdr.protocol, 8'h11);
        // empty datagram with 18 pad bytes, then a good frame back-to-back
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd8, 0, 18, 8'h00);
        model_frame(1'b0);
        b0 = beats_seen;
        send_frame(frame.size(), 1'b0);
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd12, 4, 0, 8'hB0);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        chk("t2_beats", beats_seen - b0, 4);
        chk("t2_last", last_beat, {8'hB3, 2'b10});
        // port mismatch dropped, accepted without destination check, broadcast accepted
        d0 = drops_seen;
        mk_frame(MAC, 16'h0800, IP, 16'h1235, 16'd12, 4, 0, 8'hC0);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        chk("t3_drop", drops_seen - d0, 1);
        cfg.control.check_destination = 1'b0;
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        cfg.control.check_destination = 1'b1;
        mk_frame(48'hFFFFFFFFFFFF, 16'h0800, IP, PORT, 16'd10, 2, 0, 8'hD0);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        // ARP dropped, short frame dropped, then good frame
        d0 = drops_seen;
        mk_frame(MAC, 16'h0806, IP, PORT, 16'd12, 4, 0, 8'hE0);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd12, 4, 0, 8'hE0);
        frame = frame[0:20];
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd11, 3, 0, 8'h10);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        chk("t4_drops", drops_seen - d0, 2);
        // truncated datagram: 50 of 100 bytes
        b0 = beats_seen;
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd108, 50, 0, 8'h20);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        chk("t5_beats", beats_seen - b0, 50);
        chk("t5_last", last_beat, {8'h51, 2'b11});
        // 256 bytes with random downstream backpressure
        b0 = beats_seen;
        rnd_ready = 1'b1;
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd264, 256, 0, 8'h00);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        rnd_ready = 1'b0;
        chk("t6_beats", beats_seen - b0, 256);
        // CRC-errored frame still forwarded, error pulse raised
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd12, 4, 0, 8'h60);
        model_frame(1'b1);
        send_frame(frame.size(), 1'b1);
        settle();
        // synchronous control reset mid-payload
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd108, 100, 0, 8'h40);
        model_frame(1'b0);
        send_frame(72, 1'b0);
        cfg.control.reset = 1'b1;
        @(posedge clk);
        #1;
        cfg.control.reset = 1'b0;
        exp_q.delete();
        chk("srst_tvalid", m_tvalid, 0);
        chk("srst_tdata", m_tdata, 0);
        chk("srst_header", hdr, 0);
        chk("srst_tready", s_tready, 1);
        b0 = beats_seen;
        mk_frame(MAC, 16'h0800, IP, PORT, 16'd12, 4, 0, 8'h70);
        model_frame(1'b0);
        send_frame(frame.size(), 1'b0);
        settle();
        chk("t8_beats", beats_seen - b0, 4);
        chk("t8_last", last_beat, {8'h73, 2'b10});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
